// File: rtl/frequency_meter_pkg.sv
// Shared types and helpers for the frequency meter: FSM states, gate selection
// encoding and the gate-length calculation.
package frequency_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        MEASURE
    } state_t;

    typedef enum logic [1:0] {
        GATE_1S    = 2'b00,
        GATE_100MS = 2'b01,
        GATE_10MS  = 2'b10,
        GATE_1MS   = 2'b11
    } gate_sel_t;

    // Gate length in master-clock cycles; clk_hz is always a constant, so each
    // branch folds to a literal and only the select mux remains.
    function automatic logic [31:0] gate_cycles(input int unsigned clk_hz, input gate_sel_t sel);
        case (sel)
            GATE_1S:    return clk_hz;
            GATE_100MS: return clk_hz / 10;
            GATE_10MS:  return clk_hz / 100;
            default:    return clk_hz / 1000;
        endcase
    endfunction

endpackage

// File: rtl/frequency_meter_sync_edge_detect.sv
// Brings an asynchronous input into the clock domain and emits a registered
// one-cycle pulse on each rising edge.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/frequency_meter.sv
// Counts rising edges of an asynchronous input over back-to-back gate windows
// derived from the master clock and publishes one result per gate.
module frequency_meter
    import frequency_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 10_000_000,
    parameter int          CNT_W       = 24,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             CLOCK_10MHz,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [1:0]       GATE_SEL,
    input  logic             SIG_IN,
    output logic [CNT_W-1:0] COUNT,
    output logic [1:0]       RANGE,
    output logic             VALID,
    output logic             OVERFLOW,
    output logic             BUSY
);

    localparam int                 FLUSH_W    = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    state_t             r_state;
    gate_sel_t          r_sel;
    logic [31:0]        r_gateCnt;
    logic [31:0]        r_gateMax;
    logic [CNT_W-1:0]   r_edgeCnt;
    logic               r_sat;
    logic [FLUSH_W-1:0] r_flushCnt;

    logic               w_edge;
    logic               w_atMax;
    logic               w_gateEnd;
    logic [CNT_W-1:0]   w_cntNext;
    logic               w_satNext;
    logic [31:0]        w_gateMaxNext;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clock(CLOCK_10MHz),
        .i_reset(RESET),
        .i_async(SIG_IN),
        .o_rise (w_edge)
    );

    // Next edge count including this cycle's edge, pinned at full scale.
    assign w_atMax       = (r_edgeCnt == CNT_MAX);
    assign w_cntNext     = w_atMax ? CNT_MAX : r_edgeCnt + CNT_W'(w_edge);
    assign w_satNext     = r_sat | (w_edge & w_atMax);
    assign w_gateEnd     = (r_gateCnt == r_gateMax);
    assign w_gateMaxNext = gate_cycles(CLK_HZ, gate_sel_t'(GATE_SEL)) - 32'd1;

    always_ff @(posedge CLOCK_10MHz) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_sel      <= GATE_1S;
            r_gateCnt  <= '0;
            r_gateMax  <= '0;
            r_edgeCnt  <= '0;
            r_sat      <= 1'b0;
            r_flushCnt <= '0;
            COUNT      <= '0;
            RANGE      <= 2'b00;
            VALID      <= 1'b0;
            OVERFLOW   <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            VALID <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_gateCnt  <= '0;
                    r_edgeCnt  <= '0;
                    r_sat      <= 1'b0;
                    r_flushCnt <= '0;
                    BUSY       <= 1'b0;
                    if (ENABLE) r_state <= FLUSH;
                end
                FLUSH: begin
                    if (!ENABLE) begin
                        r_state    <= IDLE;
                        r_flushCnt <= '0;
                    end else if (r_flushCnt == FLUSH_LAST) begin
                        r_state   <= MEASURE;
                        r_sel     <= gate_sel_t'(GATE_SEL);
                        r_gateMax <= w_gateMaxNext;
                        r_gateCnt <= '0;
                        r_edgeCnt <= '0;
                        r_sat     <= 1'b0;
                        BUSY      <= 1'b1;
                    end else begin
                        r_flushCnt <= r_flushCnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (!ENABLE) begin
                        r_state   <= IDLE;
                        r_gateCnt <= '0;
                        r_edgeCnt <= '0;
                        r_sat     <= 1'b0;
                        BUSY      <= 1'b0;
                    end else if (w_gateEnd) begin
                        // Publish and roll straight into the next gate with no dead cycle.
                        COUNT     <= w_cntNext;
                        OVERFLOW  <= w_satNext;
                        RANGE     <= r_sel;
                        VALID     <= 1'b1;
                        r_sel     <= gate_sel_t'(GATE_SEL);
                        r_gateMax <= w_gateMaxNext;
                        r_gateCnt <= '0;
                        r_edgeCnt <= '0;
                        r_sat     <= 1'b0;
                    end else begin
                        r_gateCnt <= r_gateCnt + 32'd1;
                        r_edgeCnt <= w_cntNext;
                        r_sat     <= w_satNext;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
